// File: rtl/param_pin_lock_pkg.sv
// Shared state encoding and entry-mode constants for the PIN lock.
package param_pin_lock_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEnter   = 3'd1,
        StCheck   = 3'd2,
        StOpen    = 3'd3,
        StNewpin  = 3'd4,
        StLockout = 3'd5
    } state_e;

    // Which action a verified PIN leads to.
    typedef enum logic {
        ModeUnlock = 1'b0,
        ModeSet    = 1'b1
    } mode_e;

endpackage

// File: rtl/pin_entry_buf.sv
// Digit collector: MSB-first shift register, digit count and inter-digit timeout timer.
module pin_entry_buf #(
    parameter int unsigned DIGIT_W  = 4,
    parameter int unsigned PIN_LEN  = 4,
    parameter int unsigned ENTRY_TO = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        enable,
    input  logic                        digit_valid,
    input  logic [DIGIT_W-1:0]          digit,
    output logic [DIGIT_W*PIN_LEN-1:0]  pin_buf,
    output logic [DIGIT_W*PIN_LEN-1:0]  shifted,
    output logic                        last_digit,
    output logic                        timeout
);

    localparam int unsigned PIN_W = DIGIT_W * PIN_LEN;
    localparam int unsigned CNT_W = $clog2(PIN_LEN + 1);
    localparam int unsigned TMR_W = $clog2(ENTRY_TO + 1);

    logic [CNT_W-1:0] count;
    logic [TMR_W-1:0] timer;

    // Buffer contents once the current digit is shifted in; also the new PIN on a last digit.
    assign shifted    = (pin_buf << DIGIT_W) | PIN_W'(digit);
    assign last_digit = enable && digit_valid && (count == CNT_W'(PIN_LEN - 1));
    assign timeout    = enable && !digit_valid && (timer == TMR_W'(ENTRY_TO - 1));

    // Shift digits in, count them, and time the gaps between them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_buf <= '0;
            count   <= '0;
            timer   <= '0;
        end else if (clear) begin
            pin_buf <= '0;
            count   <= '0;
            timer   <= '0;
        end else if (enable) begin
            if (digit_valid) begin
                pin_buf <= shifted;
                count   <= last_digit ? '0 : count + CNT_W'(1);
                timer   <= '0;
            end else if (!timeout) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/param_pin_lock.sv
// Parameterised PIN lock with unlock/PIN-change entry, retry limit and timed lockout.
module param_pin_lock #(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned PIN_LEN     = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter int unsigned ENTRY_TO    = 64,
    parameter logic [DIGIT_W*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               digit_valid,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               cmd_unlock,
    input  logic                               cmd_setpin,
    input  logic                               cmd_relock,
    input  logic                               abort,
    output logic                               unlocked,
    output logic                               busy,
    output logic                               pin_ok,
    output logic                               pin_err,
    output logic                               intrusion_alert,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

    import param_pin_lock_pkg::*;

    localparam int unsigned PIN_W = DIGIT_W * PIN_LEN;
    localparam int unsigned FW    = $clog2(MAX_TRIES + 1);
    localparam int unsigned LW    = $clog2(LOCKOUT_CYC + 1);

    state_e           state;
    mode_e            mode;
    logic [PIN_W-1:0] stored_pin;
    logic [LW-1:0]    lock_timer;
    logic [FW-1:0]    fail_next;

    logic             collecting;
    logic             buf_clear;
    logic [PIN_W-1:0] pin_buf;
    logic [PIN_W-1:0] shifted;
    logic             last_digit;
    logic             timeout;

    // Buffer runs only while collecting digits; it is held empty everywhere except CHECK,
    // which still needs the just-collected PIN for the comparison.
    always_comb begin
        collecting = (state == StEnter) || (state == StNewpin);
        buf_clear  = (collecting && abort) ||
                     (state == StIdle) || (state == StOpen) || (state == StLockout);
        fail_next  = (fail_cnt == FW'(MAX_TRIES)) ? fail_cnt : fail_cnt + FW'(1);
    end

    pin_entry_buf #(
        .DIGIT_W  (DIGIT_W),
        .PIN_LEN  (PIN_LEN),
        .ENTRY_TO (ENTRY_TO)
    ) u_entry (
        .clk         (clk),
        .rst         (rst),
        .clear       (buf_clear),
        .enable      (collecting),
        .digit_valid (digit_valid),
        .digit       (digit),
        .pin_buf     (pin_buf),
        .shifted     (shifted),
        .last_digit  (last_digit),
        .timeout     (timeout)
    );

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            mode            <= ModeUnlock;
            stored_pin      <= DEFAULT_PIN;
            lock_timer      <= '0;
            unlocked        <= 1'b0;
            busy            <= 1'b0;
            pin_ok          <= 1'b0;
            pin_err         <= 1'b0;
            intrusion_alert <= 1'b0;
            fail_cnt        <= '0;
        end else begin
            pin_ok  <= 1'b0;
            pin_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_setpin) begin
                        state <= StEnter;
                        mode  <= ModeSet;
                        busy  <= 1'b1;
                    end else if (cmd_unlock) begin
                        state <= StEnter;
                        mode  <= ModeUnlock;
                        busy  <= 1'b1;
                    end
                end
                StEnter: begin
                    if (abort || timeout) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (last_digit) begin
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    // Whole-word compare: a wrong early digit gives no early verdict.
                    if (pin_buf == stored_pin) begin
                        pin_ok   <= 1'b1;
                        fail_cnt <= '0;
                        if (mode == ModeSet) begin
                            state <= StNewpin;
                        end else begin
                            state    <= StOpen;
                            unlocked <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        pin_err  <= 1'b1;
                        fail_cnt <= fail_next;
                        if (fail_next == FW'(MAX_TRIES)) begin
                            state           <= StLockout;
                            intrusion_alert <= 1'b1;
                            lock_timer      <= '0;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                StOpen: begin
                    if (cmd_relock) begin
                        state    <= StIdle;
                        unlocked <= 1'b0;
                    end else if (cmd_setpin) begin
                        state <= StNewpin;
                        busy  <= 1'b1;
                    end
                end
                StNewpin: begin
                    if (abort || timeout) begin
                        state    <= StIdle;
                        unlocked <= 1'b0;
                        busy     <= 1'b0;
                    end else if (last_digit) begin
                        stored_pin <= shifted;
                        state      <= StIdle;
                        unlocked   <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                StLockout: begin
                    if (lock_timer == LW'(LOCKOUT_CYC - 1)) begin
                        state           <= StIdle;
                        intrusion_alert <= 1'b0;
                        fail_cnt        <= '0;
                        busy            <= 1'b0;
                    end else begin
                        lock_timer <= lock_timer + LW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_pin_lock.sv
// Self-checking bench for param_pin_lock: directed table, corner sequences, random model run.
module tb_param_pin_lock;

    logic       clk;
    logic       rst;
    logic       digit_valid;
    logic [3:0] digit;
    logic       cmd_unlock;
    logic       cmd_setpin;
    logic       cmd_relock;
    logic       abort;
    logic       unlocked;
    logic       busy;
    logic       pin_ok;
    logic       pin_err;
    logic       intrusion_alert;
    logic [1:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    param_pin_lock dut (
        .clk             (clk),
        .rst             (rst),
        .digit_valid     (digit_valid),
        .digit           (digit),
        .cmd_unlock      (cmd_unlock),
        .cmd_setpin      (cmd_setpin),
        .cmd_relock      (cmd_relock),
        .abort           (abort),
        .unlocked        (unlocked),
        .busy            (busy),
        .pin_ok          (pin_ok),
        .pin_err         (pin_err),
        .intrusion_alert (intrusion_alert),
        .fail_cnt        (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] pin;
        logic        exp_ok;
        logic        exp_unl;
        int          exp_fail;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        digit_valid = 1'b0; digit = 4'h0;
        cmd_unlock = 1'b0; cmd_setpin = 1'b0; cmd_relock = 1'b0; abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_cmd(input logic u, input logic s, input logic r);
        cmd_unlock = u; cmd_setpin = s; cmd_relock = r;
        tick();
        cmd_unlock = 1'b0; cmd_setpin = 1'b0; cmd_relock = 1'b0;
    endtask

    // Sends the top n digits of p, MSB first, with up to gap_max idle cycles between them.
    task automatic send_digits(input logic [15:0] p, input int n, input int gap_max);
        for (int i = 3; i > 3 - n; i--) begin
            digit_valid = 1'b1;
            digit = p[i*4 +: 4];
            tick();
            digit_valid = 1'b0;
            if (i > 4 - n && gap_max > 0) repeat ($urandom_range(gap_max)) tick();
        end
    endtask

    // Full entry through the verdict edge; outputs are then visible.
    task automatic attempt(input logic set, input logic [15:0] p);
        send_cmd(!set, set, 1'b0);
        send_digits(p, 4, 0);
        tick();
    endtask

    logic [15:0] m_pin;
    int          m_fail;
    bit          m_open;
    logic [15:0] guess;
    logic [15:0] newp;
    int          cnt;
    bit          err_seen;
    int          kind;
    bit          setm;

    initial begin
        rst = 1'b1;
        apply_reset();

        // Reset state
        check("rst_unlocked", 32'(unlocked), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pin_ok", 32'(pin_ok), 32'd0);
        check("rst_pin_err", 32'(pin_err), 32'd0);
        check("rst_alert", 32'(intrusion_alert), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);

        // Default PIN unlocks one edge after the last digit
        send_cmd(1'b1, 1'b0, 1'b0);
        check("enter_busy", 32'(busy), 32'd1);
        send_digits(16'h1234, 4, 0);
        check("check_unl_early", 32'(unlocked), 32'd0);
        check("check_ok_early", 32'(pin_ok), 32'd0);
        tick();
        check("open_pin_ok", 32'(pin_ok), 32'd1);
        check("open_unlocked", 32'(unlocked), 32'd1);
        check("open_busy", 32'(busy), 32'd0);
        tick();
        check("pin_ok_one_cycle", 32'(pin_ok), 32'd0);
        check("open_held", 32'(unlocked), 32'd1);
        send_cmd(1'b0, 1'b0, 1'b1);
        check("relock", 32'(unlocked), 32'd0);

        // Table of unlock attempts against the default PIN
        vecs[0] = '{16'h1235, 1'b0, 1'b0, 1};
        vecs[1] = '{16'h1234, 1'b1, 1'b1, 0};
        vecs[2] = '{16'h0000, 1'b0, 1'b0, 1};
        vecs[3] = '{16'h4321, 1'b0, 1'b0, 2};
        vecs[4] = '{16'h1234, 1'b1, 1'b1, 0};
        vecs[5] = '{16'h1204, 1'b0, 1'b0, 1};
        vecs[6] = '{16'h1234, 1'b1, 1'b1, 0};
        for (int v = 0; v < 7; v++) begin
            attempt(1'b0, vecs[v].pin);
            check($sformatf("vec%0d_ok", v), 32'(pin_ok), 32'(vecs[v].exp_ok));
            check($sformatf("vec%0d_err", v), 32'(pin_err), 32'(!vecs[v].exp_ok));
            check($sformatf("vec%0d_unl", v), 32'(unlocked), 32'(vecs[v].exp_unl));
            check($sformatf("vec%0d_fail", v), 32'(fail_cnt), 32'(vecs[v].exp_fail));
            if (vecs[v].exp_unl) send_cmd(1'b0, 1'b0, 1'b1);
        end

        // Three failures trigger a lockout that ignores all inputs
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            attempt(1'b0, 16'h1235);
            check($sformatf("lk%0d_err", k), 32'(pin_err), 32'd1);
            check($sformatf("lk%0d_fail", k), 32'(fail_cnt), 32'(k));
        end
        check("lk_alert_on", 32'(intrusion_alert), 32'd1);
        check("lk_busy", 32'(busy), 32'd1);
        cmd_unlock = 1'b1; digit_valid = 1'b1; digit = 4'h1;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!intrusion_alert) break;
            cnt++;
            tick();
        end
        cmd_unlock = 1'b0; digit_valid = 1'b0;
        check("lk_alert_cycles", 32'(cnt), 32'd16);
        check("lk_fail_cleared", 32'(fail_cnt), 32'd0);
        check("lk_exit_busy", 32'(busy), 32'd0);
        tick();
        check("lk_cmd_ignored", 32'(busy), 32'd0);
        attempt(1'b0, 16'h1234);
        check("lk_after_ok", 32'(unlocked), 32'd1);

        // PIN change via SET mode, then from OPEN; relock beats setpin
        apply_reset();
        attempt(1'b1, 16'h1234);
        check("set_ok", 32'(pin_ok), 32'd1);
        check("set_newpin_busy", 32'(busy), 32'd1);
        check("set_newpin_locked", 32'(unlocked), 32'd0);
        send_digits(16'h9876, 4, 0);
        check("set_done_busy", 32'(busy), 32'd0);
        attempt(1'b0, 16'h1234);
        check("old_pin_rejected", 32'(pin_err), 32'd1);
        attempt(1'b0, 16'h9876);
        check("new_pin_ok", 32'(pin_ok), 32'd1);
        check("new_pin_unl", 32'(unlocked), 32'd1);
        send_cmd(1'b0, 1'b1, 1'b1);
        check("relock_wins_unl", 32'(unlocked), 32'd0);
        check("relock_wins_busy", 32'(busy), 32'd0);
        attempt(1'b0, 16'h9876);
        send_cmd(1'b0, 1'b1, 1'b0);
        check("open_set_unl", 32'(unlocked), 32'd1);
        check("open_set_busy", 32'(busy), 32'd1);
        send_digits(16'h5555, 4, 0);
        check("open_set_exit", 32'(unlocked), 32'd0);
        attempt(1'b0, 16'h5555);
        check("open_set_new_ok", 32'(pin_ok), 32'd1);

        // Both commands: SET wins; abort keeps fail_cnt and stored PIN
        apply_reset();
        attempt(1'b0, 16'h1111);
        send_cmd(1'b1, 1'b1, 1'b0);
        send_digits(16'h1234, 2, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fail_kept", 32'(fail_cnt), 32'd1);
        send_cmd(1'b1, 1'b1, 1'b0);
        send_digits(16'h1234, 4, 0);
        tick();
        check("both_set_mode_unl", 32'(unlocked), 32'd0);
        check("both_set_mode_busy", 32'(busy), 32'd1);
        send_digits(16'h7777, 2, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_newpin_busy", 32'(busy), 32'd0);
        attempt(1'b0, 16'h1234);
        check("abort_pin_kept", 32'(pin_ok), 32'd1);

        // Inter-digit timeout after two digits
        apply_reset();
        send_cmd(1'b1, 1'b0, 1'b0);
        send_digits(16'h1234, 2, 0);
        err_seen = 1'b0;
        repeat (63) begin
            tick();
            if (pin_err) err_seen = 1'b1;
        end
        check("to_busy_63", 32'(busy), 32'd1);
        tick();
        if (pin_err) err_seen = 1'b1;
        check("to_busy_64", 32'(busy), 32'd0);
        check("to_no_err", 32'(err_seen), 32'd0);
        check("to_fail_kept", 32'(fail_cnt), 32'd0);

        // Reset mid-NEWPIN discards the partial new PIN
        attempt(1'b0, 16'h1234);
        send_cmd(1'b0, 1'b1, 1'b0);
        send_digits(16'h9999, 2, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_unl", 32'(unlocked), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        attempt(1'b0, 16'h1234);
        check("arst_default_pin", 32'(pin_ok), 32'd1);

        // Random transactions against a transaction-level model
        apply_reset();
        m_pin = 16'h1234; m_fail = 0; m_open = 1'b0;
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(3));
            if (m_open) begin
                if (kind < 2) begin
                    send_cmd(1'b0, 1'b0, 1'b1);
                end else begin
                    newp = 16'($urandom());
                    send_cmd(1'b0, 1'b1, 1'b0);
                    send_digits(newp, 4, 3);
                    m_pin = newp;
                end
                m_open = 1'b0;
                check("rnd_locked", 32'(unlocked), 32'd0);
                check("rnd_idle", 32'(busy), 32'd0);
            end else if (kind == 3) begin
                send_cmd(1'b1, 1'($urandom_range(1)), 1'b0);
                send_digits(16'($urandom()), int'($urandom_range(3)), 3);
                abort = 1'b1; tick(); abort = 1'b0;
                check("rnd_abort_busy", 32'(busy), 32'd0);
                check("rnd_abort_fail", 32'(fail_cnt), 32'(m_fail));
            end else begin
                setm = (kind == 2);
                guess = ($urandom_range(1) == 1) ? m_pin : 16'($urandom());
                send_cmd(!setm, setm, 1'b0);
                send_digits(guess, 4, 3);
                tick();
                if (guess == m_pin) begin
                    m_fail = 0;
                    check("rnd_ok", 32'(pin_ok), 32'd1);
                    check("rnd_fail0", 32'(fail_cnt), 32'd0);
                    if (setm) begin
                        check("rnd_set_busy", 32'(busy), 32'd1);
                        newp = 16'($urandom());
                        send_digits(newp, 4, 3);
                        m_pin = newp;
                        check("rnd_set_done", 32'(busy), 32'd0);
                    end else begin
                        check("rnd_unl", 32'(unlocked), 32'd1);
                        m_open = 1'b1;
                    end
                end else begin
                    m_fail++;
                    check("rnd_err", 32'(pin_err), 32'd1);
                    check("rnd_fail", 32'(fail_cnt), 32'(m_fail));
                    if (m_fail == 3) begin
                        check("rnd_alert", 32'(intrusion_alert), 32'd1);
                        repeat (16) tick();
                        check("rnd_alert_end", 32'(intrusion_alert), 32'd0);
                        check("rnd_lk_fail", 32'(fail_cnt), 32'd0);
                        m_fail = 0;
                    end else begin
                        check("rnd_no_alert", 32'(intrusion_alert), 32'd0);
                        check("rnd_err_idle", 32'(busy), 32'd0);
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
